// File: rtl/mux2.sv
// 2:1 mux with a combinational output and a registered output behind a
// 2-entry skid buffer (valid/ready on both sides).
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid;
  logic [1:0]       cnt, cnt_nxt;
  logic             push, pop;

  // Ternary keeps X on s visible in y where d0 and d1 differ.
  assign y    = s ? d1 : d0;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + 2'd1;
    else if (pop && !push) cnt_nxt = cnt - 2'd1;
  end

  // y_q is the queue head; skid holds the second entry while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 2'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      y_q       <= '0;
      skid      <= '0;
    end else begin
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != 2'd0);
      in_ready  <= (cnt_nxt != 2'd2);
      if ((cnt == 2'd0 && push) || (cnt == 2'd1 && push && pop))
        y_q <= y;
      else if (cnt == 2'd2 && pop)
        y_q <= skid;
      if (cnt == 2'd1 && push && !pop)
        skid <= y;
    end
  end

endmodule

// File: tb/tb_mux2.sv
// Self-checking bench for mux2: table-driven combinational vectors, a mux
// tree, directed skid-buffer sequences and randomized traffic vs a queue model.
module tb_mux2;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d0 = '0, d1 = '0, y, y_q;
  logic         s = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux2 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .d0(d0), .d1(d1), .s(s), .y(y),
    .in_valid(in_valid), .in_ready(in_ready), .y_q(y_q),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // three-mux tree selecting one of four inputs
  logic [W-1:0] t0 = 12'h111, t1 = 12'h222, t2 = 12'h333, t3 = 12'h444;
  logic [W-1:0] ta, tb, ty, tqa, tqb, tqc;
  logic         ts0 = 1'b0, ts1 = 1'b0;
  logic         tra, trb, trc, tva, tvb, tvc;

  mux2 #(.WIDTH(W)) m_a (.clk(clk), .reset(reset), .d0(t0), .d1(t1), .s(ts0), .y(ta),
    .in_valid(1'b0), .in_ready(tra), .y_q(tqa), .out_valid(tva), .out_ready(1'b0));
  mux2 #(.WIDTH(W)) m_b (.clk(clk), .reset(reset), .d0(t2), .d1(t3), .s(ts0), .y(tb),
    .in_valid(1'b0), .in_ready(trb), .y_q(tqb), .out_valid(tvb), .out_ready(1'b0));
  mux2 #(.WIDTH(W)) m_c (.clk(clk), .reset(reset), .d0(ta), .d1(tb), .s(ts1), .y(ty),
    .in_valid(1'b0), .in_ready(trc), .y_q(tqc), .out_valid(tvc), .out_ready(1'b0));

  // width extremes
  logic        sx = 1'b0, ivx = 1'b0, orx = 1'b0;
  logic [0:0]  n0 = 1'b0, n1 = 1'b1, ny1, nq1;
  logic [63:0] w0 = '0, w1 = '1, wy64, wq64;
  logic        nr1, nv1, wr64, wv64;

  mux2 #(.WIDTH(1)) m_w1 (.clk(clk), .reset(reset), .d0(n0), .d1(n1), .s(sx), .y(ny1),
    .in_valid(ivx), .in_ready(nr1), .y_q(nq1), .out_valid(nv1), .out_ready(orx));
  mux2 #(.WIDTH(64)) m_w64 (.clk(clk), .reset(reset), .d0(w0), .d1(w1), .s(sx), .y(wy64),
    .in_valid(ivx), .in_ready(wr64), .y_q(wq64), .out_valid(wv64), .out_ready(orx));

  // reference model: FIFO contents and the ready the spec promises
  logic [W-1:0] mq[$];
  bit           mready = 1'b0;

  typedef struct {
    logic         s;
    logic [W-1:0] d0, d1, y;
  } cvec_t;
  cvec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && mready;
    pp  = (mq.size() > 0) && out_ready;
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back(s ? d1 : d0);
    mready = (mq.size() < 2);
    #1;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mready));
    if (mq.size() > 0) chk("y_q", 64'(y_q), 64'(mq[0]));
  endtask

  task automatic model_reset();
    mq.delete();
    mready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 12'hABC, 12'h123, 12'hABC};
    tbl[1] = '{1'b1, 12'hABC, 12'h123, 12'h123};
    tbl[2] = '{1'b0, 12'h000, 12'hFFF, 12'h000};
    tbl[3] = '{1'b1, 12'h000, 12'hFFF, 12'hFFF};
    tbl[4] = '{1'b0, 12'hFFF, 12'h000, 12'hFFF};
    tbl[5] = '{1'b1, 12'h5A5, 12'hA5A, 12'hA5A};

    // reset state, held in reset across an edge
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_y_q", 64'(y_q), 64'd0);
    model_reset();

    // combinational path works while in reset
    foreach (tbl[i]) begin
      s = tbl[i].s; d0 = tbl[i].d0; d1 = tbl[i].d1;
      #1;
      chk("comb_tbl", 64'(y), 64'(tbl[i].y));
    end
    for (int i = 0; i < 4; i++) begin
      {ts1, ts0} = 2'(i);
      #1;
      chk("tree_sel", 64'(ty), 64'(12'h111 * (i + 1)));
    end
    sx = 1'b1; #1;
    chk("w1_y_one", 64'(ny1), 64'd1);
    chk("w64_y_one", wy64, 64'hFFFF_FFFF_FFFF_FFFF);
    sx = 1'b0; #1;
    chk("w1_y_zero", 64'(ny1), 64'd0);
    chk("w64_y_zero", wy64, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_in_ready_low", 64'(in_ready), 64'd0);
    step();
    chk("rel_in_ready_high", 64'(in_ready), 64'd1);

    // streaming with no bubbles: 5,9,5,9
    out_ready = 1'b1; d0 = 12'd5; d1 = 12'd9;
    for (int i = 0; i < 4; i++) begin
      s = i[0]; in_valid = 1'b1;
      step();
      chk("stream_yq", 64'(y_q), (i % 2) ? 64'd9 : 64'd5);
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // backpressure: third push stalls until a slot frees
    out_ready = 1'b0; s = 1'b0; in_valid = 1'b1;
    d0 = 12'h001; step(); chk("bp_rdy1", 64'(in_ready), 64'd1);
    d0 = 12'h002; step(); chk("bp_rdy2", 64'(in_ready), 64'd0);
    d0 = 12'h003; step(); chk("bp_hold", 64'(y_q), 64'h001);
    chk("bp_rdy3", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step(); chk("bp_out1", 64'(y_q), 64'h002);
    chk("bp_rdy4", 64'(in_ready), 64'd1);
    step(); chk("bp_out3", 64'(y_q), 64'h003);
    in_valid = 1'b0;
    step(); chk("bp_empty", 64'(out_valid), 64'd0);

    // reset mid-stream with two entries held
    out_ready = 1'b0; in_valid = 1'b1; d0 = 12'h0AA; step(); d0 = 12'h0BB; step();
    in_valid = 1'b0;
    chk("pre_rst_full", 64'(in_ready), 64'd0);
    reset = 1'b1; #1;
    model_reset();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_yq", 64'(y_q), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    step(); chk("post_rst_rdy", 64'(in_ready), 64'd1);
    step(); chk("post_rst_nostale", 64'(out_valid), 64'd0);

    // width extremes through the registered path
    sx = 1'b1; ivx = 1'b1; orx = 1'b1;
    step();
    chk("w1_yq_one", 64'(nq1), 64'd1);
    chk("w64_yq_one", wq64, 64'hFFFF_FFFF_FFFF_FFFF);
    sx = 1'b0;
    step();
    chk("w1_yq_zero", 64'(nq1), 64'd0);
    chk("w64_yq_zero", wq64, 64'd0);
    chk("w64_valid", 64'(wv64), 64'd1);
    ivx = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      s  = 1'($urandom);
      d0 = W'($urandom);
      d1 = W'($urandom);
      #1;
      chk("rand_y", 64'(y), 64'(s ? d1 : d0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
